// File: rtl/tx_packet_arbiter.sv
// Fixed-priority arbiter that serialises ACK / FIRE / TIME / METRIC packets onto one byte stream.
// Optional UCASPIAN_TX_TIME_DELTA_EN: short delta-encoded TIME packets when the time step is small.
module tx_packet_arbiter #(
  parameter int TIME_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [7:0]              tx_packet_data,
  output logic                    tx_packet_vld,
  input  logic                    tx_packet_rdy,
  input  logic                    ack_waiting,
  output logic                    ack_sent,
  input  logic                    output_fire_waiting,
  input  logic [7:0]              output_fire_addr,
  output logic                    output_fire_sent,
  input  logic                    time_update,
  input  logic [8*TIME_BYTES-1:0] time_current,
  output logic                    time_sent,
  input  logic                    metric_send,
  input  logic [7:0]              metric_addr,
  input  logic [7:0]              metric_value,
  output logic                    metric_read,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  typedef enum logic [1:0] {SRC_ACK, SRC_FIRE, SRC_TIME, SRC_METRIC} src_t;

  state_t      state, state_nxt;
  src_t        src, src_win;
  logic [47:0] shift, pkt;
  logic [2:0]  cnt, len;
  logic        any_req, last_acc, done;

`ifdef UCASPIAN_TX_TIME_DELTA_EN
  logic [8*TIME_BYTES-1:0] last_time, delta;
  assign delta = time_current - last_time;
`endif

  assign any_req  = ack_waiting | output_fire_waiting | time_update | metric_send;
  assign last_acc = (state == SEND) && tx_packet_rdy && (cnt == 3'd1);

  // Winner selection and packet image, left-aligned so the header is the top byte.
  always_comb begin
    src_win = SRC_METRIC;
    pkt     = {8'hB0, metric_addr, metric_value, 24'h0};
    len     = 3'd3;
    if (ack_waiting) begin
      src_win = SRC_ACK;
      pkt     = {8'hE0, 40'h0};
      len     = 3'd1;
    end else if (output_fire_waiting) begin
      src_win = SRC_FIRE;
      pkt     = {8'hC0, output_fire_addr, 32'h0};
      len     = 3'd2;
    end else if (time_update) begin
      src_win = SRC_TIME;
      pkt     = 48'({8'hA0, time_current}) << (8 * (5 - TIME_BYTES));
      len     = 3'(1 + TIME_BYTES);
`ifdef UCASPIAN_TX_TIME_DELTA_EN
      if (delta[8*TIME_BYTES-1:8] == '0) begin
        pkt = {8'hA8, delta[7:0], 32'h0};
        len = 3'd2;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SEND;
      SEND:    if (last_acc) state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift <= '0;
      cnt   <= '0;
      src   <= SRC_ACK;
`ifdef UCASPIAN_TX_TIME_DELTA_EN
      last_time <= '0;
`endif
    end else if (state == IDLE && any_req) begin
      shift <= pkt;
      cnt   <= len;
      src   <= src_win;
`ifdef UCASPIAN_TX_TIME_DELTA_EN
      if (src_win == SRC_TIME) last_time <= time_current;
`endif
    end else if (state == SEND && tx_packet_rdy) begin
      shift <= {shift[39:0], 8'h00};
      cnt   <= cnt - 3'd1;
    end
  end

  // Completion is suppressed while reset is asserted so an abandoned packet never reports done.
  always_comb begin
    tx_packet_vld    = (state == SEND);
    tx_packet_data   = (state == SEND) ? shift[47:40] : 8'h00;
    busy             = (state != IDLE);
    done             = last_acc & reset;
    ack_sent         = done && (src == SRC_ACK);
    output_fire_sent = done && (src == SRC_FIRE);
    time_sent        = done && (src == SRC_TIME);
    metric_read      = done && (src == SRC_METRIC);
  end
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Directed bench for tx_packet_arbiter: priority order, backpressure, delta TIME, mid-packet reset.
module tb_tx_packet_arbiter;
  logic        clk = 0;
  logic        reset;
  logic [7:0]  tx_packet_data;
  logic        tx_packet_vld, tx_packet_rdy;
  logic        ack_waiting, ack_sent;
  logic        output_fire_waiting, output_fire_sent;
  logic [7:0]  output_fire_addr;
  logic        time_update, time_sent;
  logic [31:0] time_current;
  logic        metric_send, metric_read;
  logic [7:0]  metric_addr, metric_value;
  logic        busy;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  tx_packet_arbiter #(.TIME_BYTES(4)) dut (
    .clk(clk), .reset(reset),
    .tx_packet_data(tx_packet_data), .tx_packet_vld(tx_packet_vld), .tx_packet_rdy(tx_packet_rdy),
    .ack_waiting(ack_waiting), .ack_sent(ack_sent),
    .output_fire_waiting(output_fire_waiting), .output_fire_addr(output_fire_addr),
    .output_fire_sent(output_fire_sent),
    .time_update(time_update), .time_current(time_current), .time_sent(time_sent),
    .metric_send(metric_send), .metric_addr(metric_addr), .metric_value(metric_value),
    .metric_read(metric_read), .busy(busy)
  );

  wire [3:0] done = {ack_sent, output_fire_sent, time_sent, metric_read};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Called at the negedge of an IDLE cycle with requests already set; walks IDLE, n SEND, GAP.
  task automatic pkt(input string tag, input int n, input logic [47:0] b, input logic [3:0] d);
    #1;
    chk({tag, "_idle_vld"}, 32'(tx_packet_vld), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    for (int i = 0; i < n; i++) begin
      nxt(); #1;
      chk({tag, "_vld"}, 32'(tx_packet_vld), 1);
      chk({tag, "_data"}, 32'(tx_packet_data), 32'(b[47-8*i -: 8]));
      chk({tag, "_done"}, 32'(done), (i == n - 1) ? 32'(d) : 0);
    end
    nxt();
    if (d[3]) ack_waiting = 0;
    if (d[2]) output_fire_waiting = 0;
    if (d[1]) time_update = 0;
    if (d[0]) metric_send = 0;
    #1;
    chk({tag, "_gap_vld"}, 32'(tx_packet_vld), 0);
    chk({tag, "_gap_busy"}, 32'(busy), 1);
    chk({tag, "_gap_done"}, 32'(done), 0);
  endtask

  task automatic do_reset();
    nxt();
    reset = 0;
    nxt(); nxt();
    reset = 1;
  endtask

`ifdef UCASPIAN_TX_TIME_DELTA_EN
  localparam int          T10_N = 2;
  localparam logic [47:0] T10_B = {8'hA8, 8'h10, 32'h0};
  localparam int          T105_N = 2;
  localparam logic [47:0] T105_B = {8'hA8, 8'h05, 32'h0};
`else
  localparam int          T10_N = 5;
  localparam logic [47:0] T10_B = {8'hA0, 32'h00000010, 8'h0};
  localparam int          T105_N = 5;
  localparam logic [47:0] T105_B = {8'hA0, 32'h00000105, 8'h0};
`endif

  initial begin
    logic [7:0] ed[6];
    logic       er[6];
    reset = 0; tx_packet_rdy = 1;
    ack_waiting = 0; output_fire_waiting = 0; output_fire_addr = 0;
    time_update = 0; time_current = 0;
    metric_send = 0; metric_addr = 0; metric_value = 0;

    // Reset state, with a request pending that must be ignored.
    nxt(); nxt();
    ack_waiting = 1;
    nxt(); #1;
    chk("rst_vld", 32'(tx_packet_vld), 0);
    chk("rst_data", 32'(tx_packet_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    ack_waiting = 0;
    reset = 1;

    // Single fire.
    nxt();
    output_fire_waiting = 1; output_fire_addr = 8'h2A;
    pkt("fire1", 2, {8'hC0, 8'h2A, 32'h0}, 4'b0100);

    // All four at once: priority order, each source holds until its pulse.
    nxt();
    ack_waiting = 1;
    output_fire_waiting = 1; output_fire_addr = 8'h05;
    time_update = 1; time_current = 32'h00000010;
    metric_send = 1; metric_addr = 8'h03; metric_value = 8'h7F;
    pkt("all_ack", 1, {8'hE0, 40'h0}, 4'b1000);
    nxt();
    pkt("all_fire", 2, {8'hC0, 8'h05, 32'h0}, 4'b0100);
    nxt();
    pkt("all_time", T10_N, T10_B, 4'b0010);
    nxt();
    pkt("all_metric", 3, {8'hB0, 8'h03, 8'h7F, 24'h0}, 4'b0001);

    // Backpressure on a metric packet; payload changes after grant must not leak in.
    nxt();
    metric_send = 1; metric_addr = 8'h11; metric_value = 8'h99;
    #1;
    chk("bp_idle_vld", 32'(tx_packet_vld), 0);
    ed = '{8'hB0, 8'h11, 8'h11, 8'h11, 8'h99, 8'h99};
    er = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      nxt();
      tx_packet_rdy = er[i];
      metric_addr = 8'h00; metric_value = 8'h00;
      #1;
      chk("bp_vld", 32'(tx_packet_vld), 1);
      chk("bp_data", 32'(tx_packet_data), 32'(ed[i]));
      chk("bp_done", 32'(done), (i == 5) ? 1 : 0);
    end
    nxt();
    metric_send = 0; tx_packet_rdy = 1;
    #1;
    chk("bp_gap_vld", 32'(tx_packet_vld), 0);
    chk("bp_gap_done", 32'(done), 0);

    // Delta TIME sequence from a clean last_time.
    do_reset();
    time_update = 1; time_current = 32'h00000100;
    pkt("t100", 5, {8'hA0, 32'h00000100, 8'h0}, 4'b0010);
    nxt();
    time_update = 1; time_current = 32'h00000105;
    pkt("t105", T105_N, T105_B, 4'b0010);
    nxt();
    time_update = 1; time_current = 32'h00000300;
    pkt("t300", 5, {8'hA0, 32'h00000300, 8'h0}, 4'b0010);

    // Reset during the 2nd byte of a TIME packet.
    do_reset();
    time_update = 1; time_current = 32'h12345678;
    #1;
    chk("mr_idle_vld", 32'(tx_packet_vld), 0);
    nxt(); #1;
    chk("mr_b0", 32'(tx_packet_data), 32'hA0);
    nxt();
    reset = 0;
    #1;
    chk("mr_b1", 32'(tx_packet_data), 32'h12);
    chk("mr_b1_done", 32'(done), 0);
    nxt();
    reset = 1; time_update = 0;
    #1;
    chk("mr_after_vld", 32'(tx_packet_vld), 0);
    chk("mr_after_busy", 32'(busy), 0);
    chk("mr_after_done", 32'(done), 0);
    nxt();
    output_fire_waiting = 1; output_fire_addr = 8'h5C;
    pkt("mr_fire", 2, {8'hC0, 8'h5C, 32'h0}, 4'b0100);

    nxt(); nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
